// File: rtl/event_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : event_counter_bank
// Description : NUM_CH independent WIDTH-bit event counters (one-shot, reload,
//               free-run) with registered REACHED pulse, sticky FLAG and IRQ.
//               Optional macro EVENT_COUNTER_BANK_TICK_EDGE_EN: rising-edge ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module event_counter_bank #(
    parameter int NUM_CH        = 4,
    parameter int WIDTH         = 8,
    parameter int TICK_IS_CLOCK = 0
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [NUM_CH-1:0]         START,
    input  logic [NUM_CH-1:0]         STOP,
    input  logic [NUM_CH-1:0]         TICK,
    input  logic [2*NUM_CH-1:0]       MODE,
    input  logic [WIDTH*NUM_CH-1:0]   INIT_VAL,
    input  logic [WIDTH*NUM_CH-1:0]   TARGET,
    input  logic [NUM_CH-1:0]         CLR_FLAG,
    output logic [WIDTH*NUM_CH-1:0]   COUNTER,
    output logic [NUM_CH-1:0]         RUNNING,
    output logic [NUM_CH-1:0]         REACHED,
    output logic [NUM_CH-1:0]         FLAG,
    output logic                      IRQ
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] c_MODE_RELOAD = 2'd1;
    localparam logic [1:0] c_MODE_FREE   = 2'd2;
    localparam logic       c_TICK_CLK    = (TICK_IS_CLOCK != 0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t           r_state;
            state_t           w_state_nxt;
            logic [WIDTH-1:0] r_cnt;
            logic [WIDTH-1:0] w_cnt_nxt;
            logic [WIDTH-1:0] w_inc;
            logic [WIDTH-1:0] w_init;
            logic [WIDTH-1:0] w_target;
            logic [1:0]       w_mode;
            logic             w_oneshot;
            logic             w_tick;
            logic             r_reached;
            logic             w_reached_nxt;
            logic             r_flag;

            assign w_init    = INIT_VAL[gi*WIDTH +: WIDTH];
            assign w_target  = TARGET[gi*WIDTH +: WIDTH];
            assign w_mode    = MODE[2*gi +: 2];
            assign w_oneshot = (w_mode != c_MODE_RELOAD) && (w_mode != c_MODE_FREE);
            assign w_inc     = r_cnt + 1'b1;

`ifdef EVENT_COUNTER_BANK_TICK_EDGE_EN
            logic r_tick_q;

            always_ff @(posedge ACLK) begin
                if (ARESET) begin
                    r_tick_q <= 1'b0;
                end else begin
                    r_tick_q <= TICK[gi];
                end
            end

            assign w_tick = c_TICK_CLK || (TICK[gi] && !r_tick_q);
`else
            assign w_tick = c_TICK_CLK || TICK[gi];
`endif

            // STOP has priority over START; counted ticks need a quiet control cycle.
            always_comb begin
                w_state_nxt   = r_state;
                w_cnt_nxt     = r_cnt;
                w_reached_nxt = 1'b0;
                if (STOP[gi]) begin
                    w_state_nxt = ST_IDLE;
                end else if (START[gi]) begin
                    w_cnt_nxt   = w_init;
                    w_state_nxt = ST_RUN;
                    if (w_init == w_target) begin
                        w_reached_nxt = 1'b1;
                        if (w_oneshot) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end else if ((r_state == ST_RUN) && w_tick) begin
                    if ((w_mode == c_MODE_RELOAD) && (r_cnt == w_target)) begin
                        w_cnt_nxt = w_init;
                    end else begin
                        w_cnt_nxt = w_inc;
                    end
                    if (w_cnt_nxt == w_target) begin
                        w_reached_nxt = 1'b1;
                        if (w_oneshot) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
            end

            always_ff @(posedge ACLK) begin
                if (ARESET) begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_reached <= 1'b0;
                    r_flag    <= 1'b0;
                end else begin
                    r_state   <= w_state_nxt;
                    r_cnt     <= w_cnt_nxt;
                    r_reached <= w_reached_nxt;
                    r_flag    <= r_reached | (r_flag & ~CLR_FLAG[gi]);
                end
            end

            assign COUNTER[gi*WIDTH +: WIDTH] = r_cnt;
            assign RUNNING[gi]                = (r_state == ST_RUN);
            assign REACHED[gi]                = r_reached;
            assign FLAG[gi]                   = r_flag;
        end
    endgenerate

    assign IRQ = |FLAG;

endmodule
`default_nettype wire

// File: tb/tb_event_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_event_counter_bank
// Description : Scoreboard bench for event_counter_bank with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_counter_bank;
    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int MODV   = 1 << WIDTH;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic                    ACLK = 1'b0;
    logic                    ARESET;
    logic [NUM_CH-1:0]       START, STOP, TICK, CLR_FLAG;
    logic [2*NUM_CH-1:0]     MODE;
    logic [WIDTH*NUM_CH-1:0] INIT_VAL, TARGET, COUNTER;
    logic [NUM_CH-1:0]       RUNNING, REACHED, FLAG;
    logic                    IRQ;

    event_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .TICK_IS_CLOCK(0)) u_dut (
        .ACLK(ACLK), .ARESET(ARESET), .START(START), .STOP(STOP), .TICK(TICK),
        .MODE(MODE), .INIT_VAL(INIT_VAL), .TARGET(TARGET), .CLR_FLAG(CLR_FLAG),
        .COUNTER(COUNTER), .RUNNING(RUNNING), .REACHED(REACHED), .FLAG(FLAG), .IRQ(IRQ)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [WIDTH*NUM_CH-1:0] cnt;
        logic [NUM_CH-1:0]       run;
        logic [NUM_CH-1:0]       rch;
        logic [NUM_CH-1:0]       flg;
        logic                    irq;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int m_state [NUM_CH];
    int m_cnt   [NUM_CH];
    bit m_rch   [NUM_CH];
    bit m_flg   [NUM_CH];
    bit m_prev  [NUM_CH];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: evaluates the rules on the current inputs and queues the
    // outputs the DUT must show after the coming edge.
    function automatic void model_step();
        exp_t e;
        e = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            int init, tgt, md;
            bit tk, rch, oneshot;
            init    = int'(INIT_VAL[c*WIDTH +: WIDTH]);
            tgt     = int'(TARGET[c*WIDTH +: WIDTH]);
            md      = int'(MODE[2*c +: 2]);
            oneshot = (md == 0) || (md == 3);
            if (ARESET) begin
                m_state[c] = S_IDLE;
                m_cnt[c]   = 0;
                m_rch[c]   = 1'b0;
                m_flg[c]   = 1'b0;
                m_prev[c]  = 1'b0;
            end else begin
                m_flg[c] = m_rch[c] || (m_flg[c] && !CLR_FLAG[c]);
`ifdef EVENT_COUNTER_BANK_TICK_EDGE_EN
                tk = TICK[c] && !m_prev[c];
`else
                tk = TICK[c];
`endif
                m_prev[c] = TICK[c];
                rch = 1'b0;
                if (STOP[c]) begin
                    m_state[c] = S_IDLE;
                end else if (START[c]) begin
                    m_cnt[c]   = init;
                    rch        = (init == tgt);
                    m_state[c] = (rch && oneshot) ? S_DONE : S_RUN;
                end else if (m_state[c] == S_RUN && tk) begin
                    if (md == 1 && m_cnt[c] == tgt) m_cnt[c] = init;
                    else                            m_cnt[c] = (m_cnt[c] + 1) % MODV;
                    rch = (m_cnt[c] == tgt);
                    if (rch && oneshot) m_state[c] = S_DONE;
                end
                m_rch[c] = rch;
            end
            e.cnt[c*WIDTH +: WIDTH] = WIDTH'(m_cnt[c]);
            e.run[c] = (m_state[c] == S_RUN);
            e.rch[c] = m_rch[c];
            e.flg[c] = m_flg[c];
        end
        e.irq = |e.flg;
        exp_q.push_back(e);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge ACLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("COUNTER", 64'(COUNTER), 64'(e.cnt));
                check("RUNNING", 64'(RUNNING), 64'(e.run));
                check("REACHED", 64'(REACHED), 64'(e.rch));
                check("FLAG",    64'(FLAG),    64'(e.flg));
                check("IRQ",     64'(IRQ),     64'(e.irq));
            end
        end
    end

    task automatic cyc();
        model_step();
        @(posedge ACLK);
        #2;
        START    = '0;
        STOP     = '0;
        CLR_FLAG = '0;
    endtask

    task automatic cfg(input int c, input int md, input int init, input int tgt);
        MODE[2*c +: 2]          = 2'(md);
        INIT_VAL[c*WIDTH +: WIDTH] = WIDTH'(init);
        TARGET[c*WIDTH +: WIDTH]   = WIDTH'(tgt);
    endtask

    initial begin : stimulus
        int edge_exp;
        ARESET = 1'b1; START = '0; STOP = '0; TICK = '0; CLR_FLAG = '0;
        MODE = '0; INIT_VAL = '0; TARGET = '0;
        @(negedge ACLK);

        // Reset with every input toggling
        for (int k = 0; k < 4; k++) begin
            START = NUM_CH'($urandom); STOP = NUM_CH'($urandom); TICK = NUM_CH'($urandom);
            CLR_FLAG = NUM_CH'($urandom); MODE = 2*NUM_CH'($urandom);
            INIT_VAL = $urandom; TARGET = $urandom;
            cyc();
        end
        ARESET = 1'b0; TICK = '0;
        cfg(0, 0, 2, 5); cfg(1, 1, 0, 3); cfg(2, 2, 250, 2); cfg(3, 2, 0, 200);
        cyc();

        // One-shot on ch0
        START[0] = 1'b1; cyc();
        for (int k = 0; k < 6; k++) begin
            TICK[0] = 1'b1; cyc();
            TICK[0] = 1'b0; cyc();
        end
        CLR_FLAG[0] = 1'b1; cyc();
        cyc();

        // Reload on ch1 with CLR overlapping a REACHED pulse
        START[1] = 1'b1; cyc();
        TICK[1] = 1'b1;
        for (int k = 0; k < 14; k++) begin
            CLR_FLAG[1] = (k >= 3 && k <= 8);
            cyc();
        end
        TICK[1] = 1'b0;

        // Free-run wrap on ch2, then STOP mid-count
        START[2] = 1'b1; cyc();
        TICK[2] = 1'b1;
        for (int k = 0; k < 270; k++) cyc();
        STOP[2] = 1'b1; cyc();
        cyc(); cyc();
        TICK[2] = 1'b0;

        // Boundaries: START+STOP, one-shot INIT==TARGET, restart in RUN, live TARGET drop
        START[1] = 1'b1; STOP[1] = 1'b1; cyc();
        cfg(0, 0, 7, 7); START[0] = 1'b1; cyc();
        TICK[0] = 1'b1; cyc(); cyc(); TICK[0] = 1'b0;
        cfg(1, 2, 10, 100); START[1] = 1'b1; cyc();
        TICK[1] = 1'b1; cyc(); cyc(); START[1] = 1'b1; cyc(); cyc(); TICK[1] = 1'b0;
        cfg(2, 0, 10, 20); START[2] = 1'b1; cyc();
        TICK[2] = 1'b1; cyc(); cyc(); cyc();
        TARGET[2*WIDTH +: WIDTH] = 8'd5;
        for (int k = 0; k < 260; k++) cyc();
        TICK[2] = 1'b0;

        // Reset mid-count one tick before the terminal count
        cfg(2, 2, 0, 3); START[2] = 1'b1; cyc();
        TICK[2] = 1'b1; cyc(); cyc();
        ARESET = 1'b1; cyc();
        ARESET = 1'b0; TICK[2] = 1'b0; cyc(); cyc();

        // Held-high tick on ch3
        cfg(3, 2, 0, 200); START[3] = 1'b1; TICK[3] = 1'b0; cyc();
        TICK[3] = 1'b1;
        for (int k = 0; k < 10; k++) cyc();
        TICK[3] = 1'b0; cyc();
`ifdef EVENT_COUNTER_BANK_TICK_EDGE_EN
        edge_exp = 1;
`else
        edge_exp = 10;
`endif
        check("held_tick_count", 64'(COUNTER[3*WIDTH +: WIDTH]), 64'(edge_exp));

        // Randomized traffic with near-target configurations
        for (int n = 0; n < 3000; n++) begin
            ARESET = ($urandom_range(0, 299) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                int init;
                START[c]    = ($urandom_range(0, 19) == 0);
                STOP[c]     = ($urandom_range(0, 39) == 0);
                TICK[c]     = $urandom_range(0, 1) == 1;
                CLR_FLAG[c] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 49) == 0) begin
                    init = int'($urandom_range(0, MODV - 1));
                    cfg(c, int'($urandom_range(0, 3)), init, (init + int'($urandom_range(0, 8))) % MODV);
                end
            end
            cyc();
        end
        ARESET = 1'b0; START = '0; STOP = '0; TICK = '0; CLR_FLAG = '0;

        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge ACLK);
        #3;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/event_counter_bank.md
Name: event_counter_bank

Overview:
- Multi-channel successor to the single event counter.
- NUM_CH independent counters, each WIDTH bits, with per-channel start/stop control and three count modes (one-shot, auto-reload, free-run).
- Each channel produces a registered REACHED pulse and a sticky FLAG; flags are ORed into one IRQ.
- Sits between event sources (tick strobes) and a control/status register block or interrupt controller.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- WIDTH, 8, counter/INIT/TARGET width per channel (2..32).
- TICK_IS_CLOCK, 0, 1 = every ACLK cycle counts as a tick for all channels (TICK ignored); 0 = use TICK.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- START  in  NUM_CH  per-channel start/restart strobe.
- STOP  in  NUM_CH  per-channel stop strobe.
- TICK  in  NUM_CH  per-channel event input.
- MODE  in  2*NUM_CH  per-channel mode: 0 one-shot, 1 reload, 2 free-run, 3 treated as 0.
- INIT_VAL  in  WIDTH*NUM_CH  per-channel load value, channel i at [i*WIDTH +: WIDTH].
- TARGET  in  WIDTH*NUM_CH  per-channel terminal value, same packing.
- CLR_FLAG  in  NUM_CH  per-channel sticky-flag clear.
- COUNTER  out  WIDTH*NUM_CH  current count, same packing.
- RUNNING  out  NUM_CH  channel in RUN state.
- REACHED  out  NUM_CH  one-cycle registered pulse on terminal count.
- FLAG  out  NUM_CH  sticky reached flag.
- IRQ  out  1  OR of FLAG.

Behaviour:
- Reset (ARESET=1 at an ACLK edge): all channels IDLE; COUNTER=0; RUNNING=0; REACHED=0; FLAG=0; IRQ=0. Reset overrides all other inputs. A reset asserted mid-count aborts the count immediately, with no REACHED pulse.
- Per-channel FSM states: IDLE, RUN, DONE. RUNNING=1 only in RUN.
- START in any state:
  - COUNTER<=INIT_VAL; state<=RUN.
  - A START while in RUN restarts the count.
  - Ticks in the START cycle are ignored.
- STOP in RUN or DONE: state<=IDLE; COUNTER holds its value.
- START and STOP in the same cycle: STOP wins.
- Counted tick: RUN state and (TICK[i]=1 or TICK_IS_CLOCK=1), with no START/STOP that cycle.
- On a counted tick, by mode:
  - One-shot: COUNTER<=COUNTER+1 (mod 2^WIDTH). If the new value equals TARGET, state<=DONE and COUNTER holds TARGET.
  - Reload: if COUNTER==TARGET, COUNTER<=INIT_VAL; otherwise COUNTER+1. Period = ((TARGET-INIT_VAL) mod 2^WIDTH)+1 ticks.
  - Free-run: COUNTER+1, wrapping modulo 2^WIDTH; never stops on TARGET.
- REACHED[i] is registered and asserted for exactly one cycle, in the first cycle COUNTER shows TARGET, when either:
  - a counted tick makes the new COUNTER equal TARGET; or
  - START loads INIT_VAL==TARGET. In one-shot this START goes directly to DONE, not RUN.
- Reload with INIT_VAL==TARGET: REACHED on every counted tick.
- TARGET and MODE are read live every cycle. INIT_VAL is sampled only at START and at reload.
- TARGET behind INIT_VAL (TARGET<INIT_VAL): counter wraps through 2^WIDTH-1 to 0, then reaches TARGET. No special case.
- DONE: counter frozen; ticks ignored; leaves DONE only via START, STOP or reset.
- FLAG[i]: set on REACHED[i]; cleared by CLR_FLAG[i]. Set wins when both occur in the same cycle.
- IRQ: combinational OR of FLAG.
- Channels are fully independent; no shared arithmetic.

Optional Feature:
- Macro: EVENT_COUNTER_BANK_TICK_EDGE_EN.
- Defined:
  - Each TICK[i] passes through a register.
  - A tick counts only on a 0->1 transition (TICK[i]=1 and previous sample 0).
  - Edge register resets to 0, so TICK held high through reset counts once on the first cycle after reset.
  - Edge detection applies only when TICK_IS_CLOCK=0.
- Undefined: TICK is level-sensitive; every cycle with TICK[i]=1 counts, and no extra register exists.

Test Plan:
1. Reset with all inputs toggling -> COUNTER=0, RUNNING=0, REACHED=0, FLAG=0, IRQ=0 on the cycle after the ARESET edge; reset mid-count aborts with no REACHED pulse.
2. Ch0 one-shot, INIT=2, TARGET=5, START then 3 single-cycle ticks -> COUNTER 2,3,4,5; REACHED[0] pulses once with COUNTER=5; state DONE; further ticks leave COUNTER=5; FLAG[0]=1, IRQ=1 until CLR_FLAG[0].
3. Ch1 reload, INIT=0, TARGET=3, TICK held high -> COUNTER 0,1,2,3,0,1,...; REACHED[1] pulses every 4th cycle; CLR_FLAG[1] coincident with REACHED[1] leaves FLAG[1]=1.
4. Ch2 free-run, WIDTH=8, INIT=250, TARGET=2, TICK high -> wraps 255->0; REACHED[2] pulses with COUNTER=2 and then every 256 ticks; STOP mid-count freezes COUNTER, RUNNING=0.
5. Boundaries: START+STOP same cycle -> IDLE; one-shot START with INIT=TARGET=7 -> DONE with a single REACHED pulse; START during RUN -> reload INIT with tick in that cycle ignored; TARGET changed live to below COUNTER -> wrap before REACHED.
6. With EVENT_COUNTER_BANK_TICK_EDGE_EN defined, TICK[3] held high 10 cycles -> COUNTER increments exactly once; without the macro -> increments 10 times.
